// File: rtl/cellrv32_gpio_arbiter.sv
// Round-robin arbiter sharing the GPIO slave port between two masters.
// One outstanding transfer: single-cycle strobe, then ack wait with timeout.
module cellrv32_gpio_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic        clk_i,
   input  logic        rstn_i,
   input  logic        m0_req_i,
   input  logic        m0_we_i,
   input  logic [31:0] m0_addr_i,
   input  logic [31:0] m0_wdata_i,
   output logic [31:0] m0_rdata_o,
   output logic        m0_ack_o,
   output logic        m0_err_o,
   input  logic        m1_req_i,
   input  logic        m1_we_i,
   input  logic [31:0] m1_addr_i,
   input  logic [31:0] m1_wdata_i,
   output logic [31:0] m1_rdata_o,
   output logic        m1_ack_o,
   output logic        m1_err_o,
   output logic [31:0] s_addr_o,
   output logic        s_rden_o,
   output logic        s_wren_o,
   output logic [31:0] s_data_o,
   input  logic [31:0] s_data_i,
   input  logic        s_ack_i
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_DONE
   } state_t;

   localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

   state_t      state_q;
   state_t      state_d;
   logic        gnt_q;
   logic        last_q;
   logic        we_q;
   logic        err_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [31:0] rdata_q;
   logic [7:0]  cnt_q;
   logic        pick;
   logic        any_req;
   logic        tmo;
   logic        done;
   logic        busy;

   assign any_req = m0_req_i | m1_req_i;
   assign tmo     = (cnt_q >= TMO_LAST);

   // gnt/last encoding: 0 = m0, 1 = m1
   always_comb begin
      pick = 1'b0;
      unique case (1'b1)
         (m0_req_i & m1_req_i): pick = ~last_q;
         (m1_req_i & ~m0_req_i): pick = 1'b1;
         default: pick = 1'b0;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE: begin
            if (any_req) begin
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (s_ack_i || tmo) begin
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
         we_q    <= 1'b0;
         err_q   <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
         cnt_q   <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (any_req) begin
                  gnt_q   <= pick;
                  we_q    <= pick ? m1_we_i : m0_we_i;
                  addr_q  <= pick ? m1_addr_i : m0_addr_i;
                  wdata_q <= pick ? m1_wdata_i : m0_wdata_i;
               end
            end
            S_ISSUE: begin
               cnt_q <= '0;
            end
            S_WAIT: begin
               if (s_ack_i) begin
                  rdata_q <= we_q ? 32'h0 : s_data_i;
                  err_q   <= 1'b0;
               end else begin
                  if (cnt_q != 8'hFF) begin
                     cnt_q <= cnt_q + 8'd1;
                  end
                  if (tmo) begin
                     rdata_q <= '0;
                     err_q   <= 1'b1;
                  end
               end
            end
            S_DONE: begin
               last_q <= gnt_q;
            end
         endcase
      end
   end

   always_comb begin
      done = (state_q == S_DONE);
      busy = (state_q == S_ISSUE) || (state_q == S_WAIT);
      s_rden_o = (state_q == S_ISSUE) & ~we_q;
      s_wren_o = (state_q == S_ISSUE) & we_q;
      s_addr_o = busy ? addr_q : 32'h0;
      s_data_o = (busy & we_q) ? wdata_q : 32'h0;
      m0_ack_o = done & ~gnt_q;
      m1_ack_o = done & gnt_q;
      m0_err_o = m0_ack_o & err_q;
      m1_err_o = m1_ack_o & err_q;
      m0_rdata_o = m0_ack_o ? rdata_q : 32'h0;
      m1_rdata_o = m1_ack_o ? rdata_q : 32'h0;
   end

endmodule

// File: tb/tb_cellrv32_gpio_arbiter.sv
// Directed bench for cellrv32_gpio_arbiter with a delay-programmable slave.
// Expected values are hand-derived cycle by cycle.
module tb_cellrv32_gpio_arbiter;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        m0_req = 1'b0;
   logic        m0_we = 1'b0;
   logic [31:0] m0_addr = '0;
   logic [31:0] m0_wdata = '0;
   logic [31:0] m0_rdata;
   logic        m0_ack;
   logic        m0_err;
   logic        m1_req = 1'b0;
   logic        m1_we = 1'b0;
   logic [31:0] m1_addr = '0;
   logic [31:0] m1_wdata = '0;
   logic [31:0] m1_rdata;
   logic        m1_ack;
   logic        m1_err;
   logic [31:0] s_addr;
   logic        s_rden;
   logic        s_wren;
   logic [31:0] s_data;
   logic [31:0] slv_data = '0;
   logic        s_ack;
   logic        slv_ack;
   logic        inj_ack = 1'b0;
   logic        slv_en = 1'b0;
   int          slv_dly = 1;
   int          slv_cnt;
   logic        outst;
   int          viol = 0;
   int          n_run = 0;
   int          n_fail = 0;
   logic        any;

   cellrv32_gpio_arbiter #(.TIMEOUT(16)) dut (
      .clk_i      (clk),
      .rstn_i     (rstn),
      .m0_req_i   (m0_req),
      .m0_we_i    (m0_we),
      .m0_addr_i  (m0_addr),
      .m0_wdata_i (m0_wdata),
      .m0_rdata_o (m0_rdata),
      .m0_ack_o   (m0_ack),
      .m0_err_o   (m0_err),
      .m1_req_i   (m1_req),
      .m1_we_i    (m1_we),
      .m1_addr_i  (m1_addr),
      .m1_wdata_i (m1_wdata),
      .m1_rdata_o (m1_rdata),
      .m1_ack_o   (m1_ack),
      .m1_err_o   (m1_err),
      .s_addr_o   (s_addr),
      .s_rden_o   (s_rden),
      .s_wren_o   (s_wren),
      .s_data_o   (s_data),
      .s_data_i   (slv_data),
      .s_ack_i    (s_ack)
   );

   always #5 clk = ~clk;

   assign s_ack = slv_ack | inj_ack;

   // slave acks slv_dly cycles after seeing the strobe
   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         slv_ack <= 1'b0;
         slv_cnt <= 0;
      end else begin
         slv_ack <= 1'b0;
         if (slv_en && (s_rden || s_wren)) begin
            slv_cnt <= slv_dly;
            if (slv_dly == 1) slv_ack <= 1'b1;
         end else if (slv_cnt > 1) begin
            slv_cnt <= slv_cnt - 1;
            if (slv_cnt == 2) slv_ack <= 1'b1;
         end else begin
            slv_cnt <= 0;
         end
      end
   end

   always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         outst <= 1'b0;
      end else begin
         if (s_rden && s_wren) viol <= viol + 1;
         if (s_rden || s_wren) begin
            if (outst) viol <= viol + 1;
            outst <= 1'b1;
         end else if (m0_ack || m1_ack) begin
            outst <= 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      chk("rst_rden", 32'(s_rden), 32'd0);
      chk("rst_wren", 32'(s_wren), 32'd0);
      chk("rst_addr", s_addr, 32'h0);
      chk("rst_ack", 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
      rstn = 1'b1;
      tick();

      // 1: m0 write, 1-cycle slave
      slv_en = 1'b1;
      slv_dly = 1;
      m0_req = 1'b1;
      m0_we = 1'b1;
      m0_addr = 32'hFFFFFC08;
      m0_wdata = 32'hA5A5A5A5;
      chk("t1_c0_wren", 32'(s_wren), 32'd0);
      tick();
      chk("t1_wren", 32'(s_wren), 32'd1);
      chk("t1_rden", 32'(s_rden), 32'd0);
      chk("t1_addr", s_addr, 32'hFFFFFC08);
      chk("t1_data", s_data, 32'hA5A5A5A5);
      tick();
      chk("t1_c2_wren", 32'(s_wren), 32'd0);
      chk("t1_c2_addr", s_addr, 32'hFFFFFC08);
      chk("t1_c2_ack", 32'(m0_ack), 32'd0);
      tick();
      chk("t1_ack", 32'(m0_ack), 32'd1);
      chk("t1_err", 32'(m0_err), 32'd0);
      chk("t1_rdata", m0_rdata, 32'h0);
      chk("t1_m1ack", 32'(m1_ack), 32'd0);
      m0_req = 1'b0;
      tick();
      chk("t1_ack_end", 32'(m0_ack), 32'd0);
      chk("t1_addr_end", s_addr, 32'h0);

      // 2: m1 read
      slv_data = 32'h12345678;
      m1_req = 1'b1;
      m1_we = 1'b0;
      m1_addr = 32'hFFFFFC00;
      tick();
      chk("t2_rden", 32'(s_rden), 32'd1);
      chk("t2_addr", s_addr, 32'hFFFFFC00);
      chk("t2_sdata", s_data, 32'h0);
      tick();
      tick();
      chk("t2_ack", 32'(m1_ack), 32'd1);
      chk("t2_rdata", m1_rdata, 32'h12345678);
      chk("t2_err", 32'(m1_err), 32'd0);
      chk("t2_m0ack", 32'(m0_ack), 32'd0);
      chk("t2_m0rdata", m0_rdata, 32'h0);
      m1_req = 1'b0;
      tick();
      chk("t2_rdata_end", m1_rdata, 32'h0);

      // 3: simultaneous requests held through four transfers
      slv_data = 32'h00000055;
      m0_req = 1'b1;
      m0_we = 1'b0;
      m0_addr = 32'h100;
      m1_req = 1'b1;
      m1_addr = 32'h200;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("t3_addr%0d", k), s_addr,
             (k % 2 == 0) ? 32'h100 : 32'h200);
         chk($sformatf("t3_rden%0d", k), 32'(s_rden), 32'd1);
         tick();
         tick();
         chk($sformatf("t3_acks%0d", k), 32'({m0_ack, m1_ack}),
             (k % 2 == 0) ? 32'd2 : 32'd1);
         tick();
      end
      m0_req = 1'b0;
      m1_req = 1'b0;
      tick();

      // 4: timeout, late ack ignored
      slv_en = 1'b0;
      slv_data = 32'hDEADBEEF;
      m0_req = 1'b1;
      m0_addr = 32'h40;
      tick();
      chk("t4_rden", 32'(s_rden), 32'd1);
      tick();
      any = 1'b0;
      repeat (15) begin
         tick();
         any = any | m0_ack | m0_err | s_rden;
      end
      chk("t4_early", 32'(any), 32'd0);
      chk("t4_addr_hold", s_addr, 32'h40);
      tick();
      chk("t4_ack", 32'(m0_ack), 32'd1);
      chk("t4_err", 32'(m0_err), 32'd1);
      chk("t4_rdata", m0_rdata, 32'h0);
      m0_req = 1'b0;
      tick();
      tick();
      inj_ack = 1'b1;
      tick();
      inj_ack = 1'b0;
      chk("t4_late_ack", 32'({m0_ack, m0_err}), 32'd0);
      chk("t4_late_rden", 32'(s_rden), 32'd0);
      tick();
      chk("t4_late_idle", 32'({m0_ack, s_rden, s_wren}), 32'd0);

      // 5: reset during WAIT, first tie afterwards goes to m0
      m0_req = 1'b1;
      m0_addr = 32'h80;
      tick();
      tick();
      tick();
      rstn = 1'b0;
      #1;
      chk("t5_rst_addr", s_addr, 32'h0);
      chk("t5_rst_out", 32'({m0_ack, m0_err, s_rden, s_wren}), 32'd0);
      m0_req = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
      chk("t5_no_ack", 32'({m0_ack, m1_ack}), 32'd0);
      slv_en = 1'b1;
      slv_dly = 1;
      m0_req = 1'b1;
      m0_we = 1'b1;
      m0_addr = 32'h10;
      m0_wdata = 32'h1;
      m1_req = 1'b1;
      m1_we = 1'b1;
      m1_addr = 32'h20;
      m1_wdata = 32'h2;
      tick();
      chk("t5_tie_addr", s_addr, 32'h10);
      chk("t5_tie_data", s_data, 32'h1);
      chk("t5_tie_wren", 32'(s_wren), 32'd1);
      tick();
      tick();
      chk("t5_acks0", 32'({m0_ack, m1_ack}), 32'd2);
      m0_req = 1'b0;
      tick();
      tick();
      chk("t5_m1_addr", s_addr, 32'h20);
      chk("t5_m1_data", s_data, 32'h2);
      tick();
      tick();
      chk("t5_acks1", 32'({m0_ack, m1_ack}), 32'd1);
      m1_req = 1'b0;
      tick();

      // 6: slow slave, m1 waits for m0 to finish
      slv_dly = 5;
      slv_data = 32'hCAFE0001;
      m0_req = 1'b1;
      m0_we = 1'b1;
      m0_addr = 32'h8;
      m0_wdata = 32'h7;
      tick();
      chk("t6_wren", 32'(s_wren), 32'd1);
      m1_req = 1'b1;
      m1_we = 1'b0;
      m1_addr = 32'h300;
      any = 1'b0;
      repeat (5) begin
         tick();
         any = any | m0_ack | m1_ack | s_rden | s_wren;
      end
      chk("t6_quiet", 32'(any), 32'd0);
      tick();
      chk("t6_acks0", 32'({m0_ack, m1_ack}), 32'd2);
      m0_req = 1'b0;
      tick();
      chk("t6_idle_rden", 32'(s_rden), 32'd0);
      tick();
      chk("t6_m1_rden", 32'(s_rden), 32'd1);
      chk("t6_m1_addr", s_addr, 32'h300);
      repeat (5) tick();
      tick();
      chk("t6_acks1", 32'({m0_ack, m1_ack}), 32'd1);
      chk("t6_rdata", m1_rdata, 32'hCAFE0001);
      m1_req = 1'b0;
      tick();
      chk("strobe_overlap", 32'(viol), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
